voice_allocator: RTL

- Polyphony scheduler that shares a fixed pool of synth voices between incoming MIDI note events.
- Sits between the MIDI receive FSM, which produces note-on/note-off events, and the voice oscillators/envelopes.
- Per event, it picks a voice in this order: retrigger the voice already playing the note, else the lowest-index free voice, else steal the oldest voice.
- Publishes per-voice note, velocity and gate registers, plus a one-cycle update strobe.

---
 rtl/voice_alloc_pkg.sv | 19 +
 rtl/voice_slot.sv | 73 +++++++
 rtl/voice_allocator.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_alloc_pkg.sv
// rtl/voice_alloc_pkg.sv - shared widths, age limits and FSM encoding for the voice allocator
// RELEASE exists only when VOICE_ALLOC_SUSTAIN_EN is defined.
package voice_alloc_pkg;

   localparam int NOTE_W    = 7;
   localparam int VEL_W     = 7;
   localparam int DEF_AGE_W = 4;
   localparam int AGE_MAX   = (1 << DEF_AGE_W) - 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SCAN    = 2'd1,
      ST_APPLY   = 2'd2
`ifdef VOICE_ALLOC_SUSTAIN_EN
      , ST_RELEASE = 2'd3
`endif
   } state_t;

endpackage

// File: rtl/voice_slot.sv
// rtl/voice_slot.sv - one voice: gate, note, velocity and saturating age (plus sustain hold flag)
// Hold flag and its controls exist only when VOICE_ALLOC_SUSTAIN_EN is defined.
module voice_slot
   import voice_alloc_pkg::*;
#(
   parameter int AGE_W = DEF_AGE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr,
   input  logic [NOTE_W-1:0] i_note,
   input  logic [VEL_W-1:0]  i_vel,
   input  logic              i_release,
   input  logic              i_age_inc,
`ifdef VOICE_ALLOC_SUSTAIN_EN
   input  logic              i_hold,
   output logic              o_held,
`endif
   output logic              o_gate,
   output logic [NOTE_W-1:0] o_note,
   output logic [VEL_W-1:0]  o_vel,
   output logic [AGE_W-1:0]  o_age
);

   localparam logic [AGE_W-1:0] AGE_SAT = {AGE_W{1'b1}};

   logic              r_gate;
   logic [NOTE_W-1:0] r_note;
   logic [VEL_W-1:0]  r_vel;
   logic [AGE_W-1:0]  r_age;
`ifdef VOICE_ALLOC_SUSTAIN_EN
   logic              r_held;
`endif

   // A write (new note or retrigger) always wins and restarts the voice's age.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gate <= 1'b0;
         r_note <= '0;
         r_vel  <= '0;
         r_age  <= '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
         r_held <= 1'b0;
`endif
      end else if (i_wr) begin
         r_gate <= 1'b1;
         r_note <= i_note;
         r_vel  <= i_vel;
         r_age  <= '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
         r_held <= 1'b0;
`endif
      end else if (i_release) begin
         r_gate <= 1'b0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
         r_held <= 1'b0;
      end else if (i_hold) begin
         r_held <= 1'b1;
`endif
      end else if (i_age_inc && r_gate && (r_age != AGE_SAT)) begin
         r_age <= r_age + 1'b1;
      end
   end

   assign o_gate = r_gate;
   assign o_note = r_note;
   assign o_vel  = r_vel;
   assign o_age  = r_age;
`ifdef VOICE_ALLOC_SUSTAIN_EN
   assign o_held = r_held;
`endif

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphony scheduler: retrigger, lowest free, else steal oldest voice
// Sustain pedal support (sustain port, RELEASE sweep) is built when VOICE_ALLOC_SUSTAIN_EN is defined.
module voice_allocator
   import voice_alloc_pkg::*;
#(
   parameter int VOICES = 8,
   parameter int IDX_W  = 3,
   parameter int AGE_W  = DEF_AGE_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ev_valid,
   output logic                     ev_ready,
   input  logic                     ev_on,
   input  logic [NOTE_W-1:0]        ev_note,
   input  logic [VEL_W-1:0]         ev_vel,
`ifdef VOICE_ALLOC_SUSTAIN_EN
   input  logic                     sustain,
`endif
   output logic [VOICES-1:0]        voice_gate,
   output logic [VOICES*NOTE_W-1:0] voice_note,
   output logic [VOICES*VEL_W-1:0]  voice_vel,
   output logic                     upd_valid,
   output logic [IDX_W-1:0]         upd_voice,
   output logic                     steal
);

   state_t            r_state, w_next;
   logic              w_accept, w_scan, w_apply, w_rel_req;

   logic [IDX_W-1:0]  r_idx;
   logic              r_is_on;
   logic [NOTE_W-1:0] r_note;
   logic [VEL_W-1:0]  r_vel;
   logic              r_match_ok, r_free_ok;
   logic [IDX_W-1:0]  r_match_idx, r_free_idx, r_old_idx;
   logic [AGE_W-1:0]  r_old_age;

   logic              r_upd_valid, r_steal;
   logic [IDX_W-1:0]  r_upd_voice;

   logic [IDX_W-1:0]  w_tgt;
   logic              w_do_steal, w_do_off;

   logic [VOICES-1:0] w_gate, w_wr, w_inc, w_off;
   logic [NOTE_W-1:0] w_note [VOICES];
   logic [VEL_W-1:0]  w_vel  [VOICES];
   logic [AGE_W-1:0]  w_age  [VOICES];

   logic              w_cur_gate;
   logic [NOTE_W-1:0] w_cur_note;
   logic [AGE_W-1:0]  w_cur_age;

`ifdef VOICE_ALLOC_SUSTAIN_EN
   logic              r_sus_d, r_rel_pend;
   logic              w_fall, w_go_rel, w_rel_step, w_do_hold;
   logic [VOICES-1:0] w_held, w_hold;

   assign w_fall    = r_sus_d & ~sustain;
   assign w_rel_req = w_fall | r_rel_pend;
   assign w_go_rel  = (r_state == ST_IDLE) & w_rel_req;

   // A falling edge seen while busy is remembered until the FSM is back in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sus_d    <= 1'b0;
         r_rel_pend <= 1'b0;
      end else begin
         r_sus_d <= sustain;
         if (w_go_rel) begin
            r_rel_pend <= 1'b0;
         end else if (w_fall) begin
            r_rel_pend <= 1'b1;
         end
      end
   end
`else
   assign w_rel_req = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      ev_ready = 1'b0;
      w_accept = 1'b0;
      w_scan   = 1'b0;
      w_apply  = 1'b0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      w_rel_step = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (!w_rel_req) begin
               ev_ready = 1'b1;
               if (ev_valid) begin
                  w_accept = 1'b1;
                  w_next   = ST_SCAN;
               end
            end
`ifdef VOICE_ALLOC_SUSTAIN_EN
            else begin
               w_next = ST_RELEASE;
            end
`endif
         end
         ST_SCAN: begin
            w_scan = 1'b1;
            if (r_idx == IDX_W'(VOICES - 1)) begin
               w_next = ST_APPLY;
            end
         end
         ST_APPLY: begin
            w_apply = 1'b1;
            w_next  = ST_IDLE;
         end
`ifdef VOICE_ALLOC_SUSTAIN_EN
         ST_RELEASE: begin
            w_rel_step = 1'b1;
            if (r_idx == IDX_W'(VOICES - 1)) begin
               w_next = ST_IDLE;
            end
         end
`endif
         default: w_next = ST_IDLE;
      endcase
   end

   assign w_cur_gate = w_gate[r_idx];
   assign w_cur_note = w_note[r_idx];
   assign w_cur_age  = w_age[r_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx       <= '0;
         r_is_on     <= 1'b0;
         r_note      <= '0;
         r_vel       <= '0;
         r_match_ok  <= 1'b0;
         r_free_ok   <= 1'b0;
         r_match_idx <= '0;
         r_free_idx  <= '0;
         r_old_idx   <= '0;
         r_old_age   <= '0;
         r_upd_valid <= 1'b0;
         r_upd_voice <= '0;
         r_steal     <= 1'b0;
      end else begin
         r_upd_valid <= 1'b0;
         r_steal     <= 1'b0;
         if (w_accept) begin
            r_is_on    <= ev_on & (ev_vel != '0);
            r_note     <= ev_note;
            r_vel      <= ev_vel;
            r_idx      <= '0;
            r_match_ok <= 1'b0;
            r_free_ok  <= 1'b0;
            r_old_idx  <= '0;
            r_old_age  <= '0;
         end
         if (w_scan) begin
            if (!r_match_ok && w_cur_gate && (w_cur_note == r_note)) begin
               r_match_ok  <= 1'b1;
               r_match_idx <= r_idx;
            end
            if (!r_free_ok && !w_cur_gate) begin
               r_free_ok  <= 1'b1;
               r_free_idx <= r_idx;
            end
            // Strict compare keeps the lowest index among equally old voices.
            if (w_cur_age > r_old_age) begin
               r_old_age <= w_cur_age;
               r_old_idx <= r_idx;
            end
            r_idx <= r_idx + 1'b1;
         end
         if (w_apply) begin
            r_upd_valid <= r_is_on | r_match_ok;
            r_upd_voice <= w_tgt;
            r_steal     <= w_do_steal;
         end
`ifdef VOICE_ALLOC_SUSTAIN_EN
         if (w_go_rel) begin
            r_idx <= '0;
         end
         if (w_rel_step) begin
            r_idx <= r_idx + 1'b1;
            if (w_held[r_idx]) begin
               r_upd_valid <= 1'b1;
               r_upd_voice <= r_idx;
            end
         end
`endif
      end
   end

   always_comb begin
      w_tgt      = r_old_idx;
      w_do_steal = 1'b0;
      w_do_off   = 1'b0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      w_do_hold  = 1'b0;
`endif
      if (r_is_on) begin
         if (r_match_ok) begin
            w_tgt = r_match_idx;
         end else if (r_free_ok) begin
            w_tgt = r_free_idx;
         end else begin
            w_do_steal = 1'b1;
         end
      end else if (r_match_ok) begin
         w_tgt = r_match_idx;
`ifdef VOICE_ALLOC_SUSTAIN_EN
         if (sustain) begin
            w_do_hold = 1'b1;
         end else begin
            w_do_off = 1'b1;
         end
`else
         w_do_off = 1'b1;
`endif
      end
   end

   always_comb begin
      w_wr  = '0;
      w_inc = '0;
      w_off = '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      w_hold = '0;
`endif
      for (int i = 0; i < VOICES; i++) begin
         if (w_apply) begin
            if (IDX_W'(i) == w_tgt) begin
               w_wr[i]  = r_is_on;
               w_off[i] = w_do_off;
`ifdef VOICE_ALLOC_SUSTAIN_EN
               w_hold[i] = w_do_hold;
`endif
            end else begin
               w_inc[i] = r_is_on;
            end
         end
`ifdef VOICE_ALLOC_SUSTAIN_EN
         if (w_rel_step && (IDX_W'(i) == r_idx) && w_held[i]) begin
            w_off[i] = 1'b1;
         end
`endif
      end
   end

   for (genvar gi = 0; gi < VOICES; gi++) begin : g_slot
      voice_slot #(
         .AGE_W     (AGE_W)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .i_wr      (w_wr[gi]),
         .i_note    (r_note),
         .i_vel     (r_vel),
         .i_release (w_off[gi]),
         .i_age_inc (w_inc[gi]),
`ifdef VOICE_ALLOC_SUSTAIN_EN
         .i_hold    (w_hold[gi]),
         .o_held    (w_held[gi]),
`endif
         .o_gate    (w_gate[gi]),
         .o_note    (w_note[gi]),
         .o_vel     (w_vel[gi]),
         .o_age     (w_age[gi])
      );
      assign voice_note[gi*NOTE_W +: NOTE_W] = w_note[gi];
      assign voice_vel[gi*VEL_W +: VEL_W]    = w_vel[gi];
   end

   assign voice_gate = w_gate;
   assign upd_valid  = r_upd_valid;
   assign upd_voice  = r_upd_voice;
   assign steal      = r_steal;

endmodule
